// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the core's data load/store port. One request is
//   accepted at a time. After LATENCY wait cycles the request commits, which
//   means byte-addressed storage is read or written once. A single response
//   then carries the extended load data or an error flag.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   req_valid/ready     request handshake
//   req_write           1 = store, 0 = load
//   req_addr            64-bit byte address
//   req_wdata           store data; only the low `size` bytes are written
//   req_funct3          RV64 load/store funct3
//   resp_valid/ready    response handshake
//   resp_rdata          extended load data; 0 for stores and errors
//   resp_err            request rejected (misaligned, out of range, illegal)
module dmem_responder #(
  parameter int DEPTH_BYTES = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int WORDS = DEPTH_BYTES / 8;
  localparam int IW    = AW - 3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_err;
  logic [63:0] r_rdata;
  logic        r_write;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [2:0]  r_funct3;

  logic        w_accept;
  logic        w_commit;
  logic        w_write;
  logic [63:0] w_addr;
  logic [63:0] w_wdata;
  logic [2:0]  w_funct3;
  logic [3:0]  w_size;
  logic [2:0]  w_off;
  logic [IW-1:0] w_idx;
  logic [64:0] w_end;
  logic        w_misaligned;
  logic        w_oor;
  logic        w_illegal;
  logic        w_err;
  logic [63:0] w_wdata_sh;
  logic [7:0]  w_rd_byte [8];
  logic        w_we [8];
  logic [63:0] w_rd_word;
  logic [63:0] w_rd_sh;
  logic [63:0] w_load;
  logic [63:0] w_result;

  assign w_accept = (r_state == IDLE) && r_req_ready && req_valid;

  // With zero latency the commit happens on the accepting edge itself, so the
  // live request inputs are used; otherwise the captured copy is used.
  assign w_commit = !reset &&
                    (((LATENCY == 0) && w_accept) ||
                     ((r_state == WAIT) && (r_cnt == 4'd1)));

  assign w_write  = (r_state == IDLE) ? req_write  : r_write;
  assign w_addr   = (r_state == IDLE) ? req_addr   : r_addr;
  assign w_wdata  = (r_state == IDLE) ? req_wdata  : r_wdata;
  assign w_funct3 = (r_state == IDLE) ? req_funct3 : r_funct3;

  assign w_size = 4'd1 << w_funct3[1:0];
  assign w_off  = w_addr[2:0];
  assign w_idx  = w_addr[AW-1:3];

  // Size 8 gives w_size[2:0]=0, and 0-1 wraps to the 3'b111 alignment mask.
  assign w_misaligned = (w_off & (w_size[2:0] - 3'd1)) != 3'd0;
  // 65-bit sum so addresses near 2^64 cannot wrap back into range.
  assign w_end        = {1'b0, w_addr} + 65'(w_size);
  assign w_oor        = w_end > 65'(DEPTH_BYTES);
  assign w_illegal    = w_write ? w_funct3[2] : (w_funct3 == 3'b111);
  assign w_err        = w_misaligned || w_oor || w_illegal;

  assign w_wdata_sh = w_wdata << {w_off, 3'b000};

  // One byte-wide array per lane. An aligned access never crosses a 64-bit
  // word, so every access touches exactly one row.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] r_mem [WORDS];

      assign w_we[gi] = w_commit && w_write && !w_err &&
                        (4'(gi) >= {1'b0, w_off}) &&
                        (4'(gi) < ({1'b0, w_off} + w_size));

      always_ff @(posedge clk) begin
        if (w_we[gi]) begin
          r_mem[w_idx] <= w_wdata_sh[gi*8 +: 8];
        end
      end

      assign w_rd_byte[gi] = r_mem[w_idx];
    end
  endgenerate

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      w_rd_word[i*8 +: 8] = w_rd_byte[i];
    end
    w_rd_sh = w_rd_word >> {w_off, 3'b000};
    case (w_funct3)
      3'b000:  w_load = {{56{w_rd_sh[7]}}, w_rd_sh[7:0]};
      3'b001:  w_load = {{48{w_rd_sh[15]}}, w_rd_sh[15:0]};
      3'b010:  w_load = {{32{w_rd_sh[31]}}, w_rd_sh[31:0]};
      3'b011:  w_load = w_rd_sh;
      3'b100:  w_load = {56'd0, w_rd_sh[7:0]};
      3'b101:  w_load = {48'd0, w_rd_sh[15:0]};
      3'b110:  w_load = {32'd0, w_rd_sh[31:0]};
      default: w_load = '0;
    endcase
    w_result = (w_write || w_err) ? 64'd0 : w_load;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= 64'd0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_write     <= req_write;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_funct3    <= req_funct3;
            r_req_ready <= 1'b0;
            if (LATENCY == 0) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_rdata      <= w_result;
              r_err        <= w_err;
            end else begin
              r_state <= WAIT;
              r_cnt   <= 4'(LATENCY);
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_rdata      <= w_result;
            r_err        <= w_err;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_rdata      <= 64'd0;
            r_err        <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
